image_storage_dbuf: RTL and testbench
=====================================

// Module: image_storage_dbuf
// PURPOSE
//  Parametrised, double-buffered frame store for the VGA pipeline; generalises the fixed-image store.
//  Holds two banks of H_RES x V_RES pixels of COLOR_W bits.
//  - Read side: streams the front bank to the VGA output, integer-upscaled by 2^SCALE_LOG2.
//  - Write side: pixel writes and a hardware clear target the back bank; bank swap occurs only on FRAME_START.
// PARAMETERS
//  H_RES         160     stored image width in pixels
//  V_RES         120     stored image height in pixels
//  COLOR_W       12      bits per pixel (RGB444 default)
//  SCALE_LOG2    2       screen pixels per stored pixel = 2^SCALE_LOG2, both axes
//  BORDER_COLOR  12'h000 COLOR value driven for on-screen coords outside the scaled image
//  Derived: AW = $clog2(H_RES*V_RES); XW = $clog2(H_RES); YW = $clog2(V_RES); screen coords 11 bits
// PORTS
//  CLK          in   1        system clock; all logic on rising edge
//  RESET        in   1        asynchronous, active-high reset
//  CE           in   1        pixel-clock enable; advances read pipeline and swap logic only
//  PIX_X        in   11       current screen column from timing generator
//  PIX_Y        in   11       current screen row from timing generator
//  VIDEO_ON     in   1        active-video flag aligned with PIX_X/PIX_Y
//  FRAME_START  in   1        one-CE pulse at first pixel of frame (0,0)
//  COLOR        out  COLOR_W  pixel colour, 2 CE-cycles after PIX_X/PIX_Y
//  COLOR_VALID  out  1        VIDEO_ON delayed 2 CE-cycles
//  WR_EN        in   1        write request, back bank
//  WR_X         in   XW       write column
//  WR_Y         in   YW       write row
//  WR_DATA      in   COLOR_W  write colour
//  WR_READY     out  1        write accepted when WR_EN & WR_READY
//  CLR_REQ      in   1        start clearing back bank (level sampled in IDLE)
//  CLR_DATA     in   COLOR_W  fill colour, latched at clear start
//  SWAP_REQ     in   1        request bank swap at next FRAME_START
//  BUSY         out  1        clear running or swap pending
//  FRONT_BANK   out  1        index of bank being displayed
// BEHAVIOUR
//  Reset: COLOR=0, COLOR_VALID=0, WR_READY=0, BUSY=0, FRONT_BANK=0; FSM=IDLE, clear counter=0.
//    WR_READY rises the first CLK after RESET deasserts. RAM contents are not reset.
//  Read pipeline (advances only when CE=1):
//    st1: sx=PIX_X>>SCALE_LOG2, sy=PIX_Y>>SCALE_LOG2.
//      in_img = VIDEO_ON & sx<H_RES & sy<V_RES.
//      Register addr = sy*H_RES+sx (AW bits), plus in_img and VIDEO_ON.
//    st2: synchronous RAM read of front bank.
//      COLOR = in_img ? ram : (VIDEO_ON ? BORDER_COLOR : 0); COLOR_VALID = VIDEO_ON delayed.
//    CE=0 holds all pipeline registers.
//  Write port: a write accepted on cycle n is stored in the back bank at WR_Y*H_RES+WR_X on edge n.
//    Out-of-range WR_X/WR_Y are accepted and discarded (no RAM write). Writes never touch the front bank.
//  FSM, runs every CLK independent of CE:
//    IDLE: WR_READY=1, BUSY=0.
//      CLR_REQ -> CLEAR (latch CLR_DATA, count=0).
//      Else SWAP_REQ -> SWAP_WAIT.
//      CLR_REQ wins if both are asserted.
//    CLEAR: WR_READY=0, BUSY=1; writes CLR_DATA to back[count] each CLK.
//      count==H_RES*V_RES-1 -> IDLE. Length is exactly H_RES*V_RES cycles.
//    SWAP_WAIT: WR_READY=0, BUSY=1.
//      On CE & FRAME_START: FRONT_BANK toggles, -> IDLE.
//      The new bank is first visible for the pixel presented with FRAME_START (2-cycle latency as normal).
//  Mid-frame swaps are impossible: FRONT_BANK changes only on CE & FRAME_START.
//  SWAP_REQ / CLR_REQ in CLEAR or SWAP_WAIT are ignored (not queued).
//  RESET mid-CLEAR or mid-SWAP_WAIT aborts to IDLE with FRONT_BANK=0; a partially cleared bank stays partial.
//  RAM: two H_RES*V_RES x COLOR_W arrays, or one 2x array addressed by {bank, addr}.
//    One read port (front) and one write port (back); no read/write collision is possible.
// TESTING
//  1 Reset: assert RESET async mid-cycle -> COLOR=0, COLOR_VALID=0, FRONT_BANK=0, WR_READY=0 immediately; WR_READY=1 one CLK after release.
//  2 Write+swap: write (3,2)=12'hF00 -> SWAP_REQ -> FRAME_START -> screen (12..15, 8..11) shows 12'hF00 two CE-cycles later; FRONT_BANK=1.
//  3 Scaling/border: PIX_X=640, PIX_Y=0, VIDEO_ON=1 -> COLOR=BORDER_COLOR; VIDEO_ON=0 -> COLOR=0, COLOR_VALID=0.
//  4 Clear: CLR_REQ with CLR_DATA=12'h0F0 -> BUSY=1 and WR_READY=0 for exactly 19200 CLKs; after swap every pixel reads 12'h0F0.
//  5 Swap timing: SWAP_REQ mid-frame -> FRONT_BANK unchanged until CE&FRAME_START; WR_EN during SWAP_WAIT is not accepted.
//  6 Bounds/CE: write WR_X=200 -> no RAM change; hold CE=0 for 5 CLKs -> COLOR/COLOR_VALID frozen.

Source files
------------

// File: rtl/image_storage_dbuf.sv
// -----------------------------------------------------------------------------
// image_storage_dbuf
// Double-buffered frame store for the VGA pipeline. Two banks of H_RES x V_RES
// pixels of COLOR_W bits. The front bank is streamed to the screen with
// 2^SCALE_LOG2 integer upscaling. Pixel writes and a hardware clear target the
// back bank. The banks swap only on a CE-qualified FRAME_START.
//
// Ports
//   CLK, RESET       clock, asynchronous active-high reset
//   CE               pixel-clock enable (read pipeline and swap only)
//   PIX_X/PIX_Y      screen coordinates from the timing generator (11 bits)
//   VIDEO_ON         active-video flag aligned with PIX_X/PIX_Y
//   FRAME_START      one-CE pulse at screen pixel (0,0)
//   COLOR            pixel colour, 2 CE-cycles after PIX_X/PIX_Y
//   COLOR_VALID      VIDEO_ON delayed by 2 CE-cycles
//   WR_EN/WR_X/WR_Y/WR_DATA/WR_READY  back-bank write port
//   CLR_REQ/CLR_DATA hardware clear of the back bank
//   SWAP_REQ         swap the banks at the next frame start
//   BUSY             clear running or swap pending
//   FRONT_BANK       index of the bank being displayed
// -----------------------------------------------------------------------------
module image_storage_dbuf #(
    parameter int                  H_RES        = 160,
    parameter int                  V_RES        = 120,
    parameter int                  COLOR_W      = 12,
    parameter int                  SCALE_LOG2   = 2,
    parameter logic [COLOR_W-1:0]  BORDER_COLOR = '0,
    localparam int                 NPIX         = H_RES * V_RES,
    localparam int                 AW           = $clog2(NPIX),
    localparam int                 XW           = $clog2(H_RES),
    localparam int                 YW           = $clog2(V_RES)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CE,
    input  logic [10:0]        PIX_X,
    input  logic [10:0]        PIX_Y,
    input  logic               VIDEO_ON,
    input  logic               FRAME_START,
    output logic [COLOR_W-1:0] COLOR,
    output logic               COLOR_VALID,
    input  logic               WR_EN,
    input  logic [XW-1:0]      WR_X,
    input  logic [YW-1:0]      WR_Y,
    input  logic [COLOR_W-1:0] WR_DATA,
    output logic               WR_READY,
    input  logic               CLR_REQ,
    input  logic [COLOR_W-1:0] CLR_DATA,
    input  logic               SWAP_REQ,
    output logic               BUSY,
    output logic               FRONT_BANK
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SWAP_WAIT} state_t;

    // ------------------------------------------------------------------ FSM
    state_t             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [COLOR_W-1:0] clr_data_q, clr_data_d;
    logic               front_q, front_d;
    logic               wr_ready_q, wr_ready_d;
    logic               busy_q, busy_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_data_d = clr_data_q;
        front_d    = front_q;
        unique case (state_q)
            S_IDLE: begin
                if (CLR_REQ) begin
                    state_d    = S_CLEAR;
                    cnt_d      = '0;
                    clr_data_d = CLR_DATA;
                end else if (SWAP_REQ) begin
                    state_d = S_SWAP_WAIT;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NPIX - 1)) state_d = S_IDLE;
            end
            S_SWAP_WAIT: begin
                if (CE && FRAME_START) begin
                    front_d = ~front_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status flags are registered so they describe the state being entered.
        wr_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            clr_data_q <= '0;
            front_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_data_q <= clr_data_d;
            front_q    <= front_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
        end
    end

    // ------------------------------------------------------------ write port
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [COLOR_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = AW'(32'(WR_Y) * H_RES + 32'(WR_X));
        mem_wdata = WR_DATA;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = clr_data_q;
        end else if (WR_EN && wr_ready_q) begin
            // Out-of-range coordinates are accepted but dropped.
            mem_we = (32'(WR_X) < H_RES) && (32'(WR_Y) < V_RES);
        end
    end

    // ------------------------------------------------------- read pipeline
    logic [10:0]        sx, sy;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               in_img1_q, in_img1_d;
    logic               vid1_q, vid1_d;
    logic               in_img2_q, in_img2_d;
    logic               vid2_q, vid2_d;
    logic [COLOR_W-1:0] rd_data_q;

    always_comb begin
        sx        = PIX_X >> SCALE_LOG2;
        sy        = PIX_Y >> SCALE_LOG2;
        rd_addr_d = rd_addr_q;
        in_img1_d = in_img1_q;
        vid1_d    = vid1_q;
        in_img2_d = in_img2_q;
        vid2_d    = vid2_q;
        if (CE) begin
            rd_addr_d = AW'(32'(sy) * H_RES + 32'(sx));
            in_img1_d = VIDEO_ON && (32'(sx) < H_RES) && (32'(sy) < V_RES);
            vid1_d    = VIDEO_ON;
            in_img2_d = in_img1_q;
            vid2_d    = vid1_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_addr_q <= '0;
            in_img1_q <= 1'b0;
            vid1_q    <= 1'b0;
            in_img2_q <= 1'b0;
            vid2_q    <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            in_img1_q <= in_img1_d;
            vid1_q    <= vid1_d;
            in_img2_q <= in_img2_d;
            vid2_q    <= vid2_d;
        end
    end

    // ------------------------------------------------------------------ RAM
    // Both banks live in one array addressed by {bank, addr}; the write side
    // always uses the back bank and the read side the front bank.
    logic [COLOR_W-1:0] mem [2**(AW+1)];

    // NOTE: the RAM and its read register have no reset so the array maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[{~front_q, mem_waddr}] <= mem_wdata;
        if (CE)     rd_data_q <= mem[{front_q, rd_addr_q}];
    end

    // ------------------------------------------------------------- outputs
    assign COLOR       = in_img2_q ? rd_data_q : (vid2_q ? BORDER_COLOR : '0);
    assign COLOR_VALID = vid2_q;
    assign WR_READY    = wr_ready_q;
    assign BUSY        = busy_q;
    assign FRONT_BANK  = front_q;

endmodule

// File: tb/tb_image_storage_dbuf.sv
// -----------------------------------------------------------------------------
// tb_image_storage_dbuf
// Directed bench for image_storage_dbuf at 160x120, RGB444, x4 scaling, with a
// non-zero border colour so border and blanking are distinguishable.
// -----------------------------------------------------------------------------
module tb_image_storage_dbuf;

    localparam logic [11:0] BORDER = 12'h555;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CE;
    logic [10:0] PIX_X, PIX_Y;
    logic        VIDEO_ON, FRAME_START;
    logic [11:0] COLOR;
    logic        COLOR_VALID;
    logic        WR_EN;
    logic [7:0]  WR_X;
    logic [6:0]  WR_Y;
    logic [11:0] WR_DATA;
    logic        WR_READY;
    logic        CLR_REQ;
    logic [11:0] CLR_DATA;
    logic        SWAP_REQ;
    logic        BUSY;
    logic        FRONT_BANK;

    int n_checks = 0;
    int n_fail   = 0;

    image_storage_dbuf #(.BORDER_COLOR(BORDER)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y), .VIDEO_ON(VIDEO_ON), .FRAME_START(FRAME_START),
        .COLOR(COLOR), .COLOR_VALID(COLOR_VALID),
        .WR_EN(WR_EN), .WR_X(WR_X), .WR_Y(WR_Y), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
        .CLR_REQ(CLR_REQ), .CLR_DATA(CLR_DATA), .SWAP_REQ(SWAP_REQ),
        .BUSY(BUSY), .FRONT_BANK(FRONT_BANK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] x, input logic [6:0] y, input logic [11:0] d);
        WR_EN = 1'b1; WR_X = x; WR_Y = y; WR_DATA = d;
        tick();
        WR_EN = 1'b0;
    endtask

    // Present one screen pixel with CE held high and check it two CE-cycles later.
    task automatic read_pix(input string tag, input logic [10:0] x, input logic [10:0] y,
                            input logic von, input logic [11:0] exp_c, input logic exp_v);
        CE = 1'b1; FRAME_START = 1'b0;
        PIX_X = x; PIX_Y = y; VIDEO_ON = von;
        tick();
        tick();
        check({tag, " color"}, 32'(COLOR), 32'(exp_c));
        check({tag, " valid"}, 32'(COLOR_VALID), 32'(exp_v));
    endtask

    initial begin
        int cnt;
        RESET = 1'b1; CE = 1'b0; PIX_X = '0; PIX_Y = '0; VIDEO_ON = 1'b0; FRAME_START = 1'b0;
        WR_EN = 1'b0; WR_X = '0; WR_Y = '0; WR_DATA = '0;
        CLR_REQ = 1'b0; CLR_DATA = '0; SWAP_REQ = 1'b0;

        // Reset state and WR_READY rising one clock after release
        repeat (3) tick();
        check("rst color", 32'(COLOR), 32'h0);
        check("rst valid", 32'(COLOR_VALID), 32'h0);
        check("rst front", 32'(FRONT_BANK), 32'h0);
        check("rst busy", 32'(BUSY), 32'h0);
        RESET = 1'b0;
        check("rdy before edge", 32'(WR_READY), 32'h0);
        tick();
        check("rdy after edge", 32'(WR_READY), 32'h1);

        // Clear back bank (1) with 0F0; a swap request during the clear is dropped
        CLR_DATA = 12'h0F0; CLR_REQ = 1'b1;
        tick();
        CLR_REQ = 1'b0;
        check("clr busy", 32'(BUSY), 32'h1);
        check("clr rdy", 32'(WR_READY), 32'h0);
        cnt = 1;
        SWAP_REQ = 1'b1;
        tick();
        SWAP_REQ = 1'b0;
        if (BUSY) cnt++;
        while (BUSY && cnt < 30000) begin
            tick();
            if (BUSY) cnt++;
        end
        check("clr length", 32'(cnt), 32'd19200);
        check("clr rdy end", 32'(WR_READY), 32'h1);
        tick();
        check("swap not queued", 32'(BUSY), 32'h0);

        // Back-bank writes, including an out-of-range column and the last pixel
        wr(8'd3, 7'd2, 12'hF00);
        wr(8'd200, 7'd0, 12'hBAD);
        wr(8'd159, 7'd119, 12'hABC);

        // Swap request: waits for CE & FRAME_START, blocks writes meanwhile
        SWAP_REQ = 1'b1;
        tick();
        SWAP_REQ = 1'b0;
        check("swap busy", 32'(BUSY), 32'h1);
        check("swap rdy", 32'(WR_READY), 32'h0);
        wr(8'd5, 7'd5, 12'h123);
        CE = 1'b1;
        repeat (3) tick();
        check("front mid-frame", 32'(FRONT_BANK), 32'h0);
        CE = 1'b0; FRAME_START = 1'b1;
        tick();
        check("front fs no ce", 32'(FRONT_BANK), 32'h0);
        CE = 1'b1; PIX_X = 11'd12; PIX_Y = 11'd8; VIDEO_ON = 1'b1;
        tick();
        FRAME_START = 1'b0;
        check("front swapped", 32'(FRONT_BANK), 32'h1);
        check("swap done busy", 32'(BUSY), 32'h0);
        check("swap done rdy", 32'(WR_READY), 32'h1);
        tick();
        check("fs pixel color", 32'(COLOR), 32'hF00);

        // Scaled image, border and blanking
        read_pix("px 15,11", 11'd15, 11'd11, 1'b1, 12'hF00, 1'b1);
        read_pix("px 11,8", 11'd11, 11'd8, 1'b1, 12'h0F0, 1'b1);
        read_pix("px 12,12", 11'd12, 11'd12, 1'b1, 12'h0F0, 1'b1);
        read_pix("px 639,479", 11'd639, 11'd479, 1'b1, 12'hABC, 1'b1);
        read_pix("border x", 11'd640, 11'd0, 1'b1, BORDER, 1'b1);
        read_pix("border y", 11'd0, 11'd480, 1'b1, BORDER, 1'b1);
        read_pix("blank", 11'd12, 11'd8, 1'b0, 12'h000, 1'b0);
        read_pix("oob write", 11'd160, 11'd4, 1'b1, 12'h0F0, 1'b1);
        read_pix("swapwait write", 11'd20, 11'd20, 1'b1, 12'h0F0, 1'b1);

        // Write to the new back bank (0) leaves the displayed bank alone
        wr(8'd3, 7'd2, 12'h777);
        read_pix("front untouched", 11'd13, 11'd9, 1'b1, 12'hF00, 1'b1);

        // CE low freezes the outputs
        CE = 1'b0; PIX_X = 11'd640; PIX_Y = 11'd0; VIDEO_ON = 1'b0;
        repeat (5) tick();
        check("ce hold color", 32'(COLOR), 32'hF00);
        check("ce hold valid", 32'(COLOR_VALID), 32'h1);
        CE = 1'b1;
        tick();
        tick();
        check("ce resume color", 32'(COLOR), 32'h0);
        check("ce resume valid", 32'(COLOR_VALID), 32'h0);

        // Asynchronous reset mid-cycle
        read_pix("pre reset", 11'd12, 11'd8, 1'b1, 12'hF00, 1'b1);
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        check("arst color", 32'(COLOR), 32'h0);
        check("arst valid", 32'(COLOR_VALID), 32'h0);
        check("arst front", 32'(FRONT_BANK), 32'h0);
        check("arst rdy", 32'(WR_READY), 32'h0);
        tick();
        RESET = 1'b0;
        check("arst rdy held", 32'(WR_READY), 32'h0);
        tick();
        check("arst rdy rise", 32'(WR_READY), 32'h1);
        read_pix("bank0 after rst", 11'd12, 11'd8, 1'b1, 12'h777, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
